// File: rtl/bp_be_wb_pkg.sv
// Shared writeback types: source identifiers and the default-width write request payload.
package bp_be_wb_pkg;

  localparam int unsigned wb_dword_width_gp      = 64;
  localparam int unsigned wb_reg_addr_width_gp   = 5;
  localparam int unsigned wb_starve_cnt_width_gp = 4;

  typedef enum logic [1:0] {
    e_wb_src_none,
    e_wb_src_pipe,
    e_wb_src_long,
    e_wb_src_mem
  } bp_be_wb_src_e;

  typedef struct packed {
    logic                            v;
    logic [wb_reg_addr_width_gp-1:0] addr;
    logic [wb_dword_width_gp-1:0]    data;
  } bp_be_wb_req_s;

endpackage

// File: rtl/bp_be_wb_rr_arb2.sv
// Two-input round-robin arbiter; after a grant the pointer favours the other input.
module bp_be_wb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] v,
  input  logic       en,
  output logic [1:0] grant
);

  // ptr == 0 favours v[0], ptr == 1 favours v[1]
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (v[0] && (!v[1] || !ptr)) grant = 2'b01;
      else if (v[1])               grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (|grant) ptr <= grant[0];
  end

endmodule

// File: rtl/bp_be_rf_wb_arbiter.sv
// Arbitrates the single integer regfile write port between pipe, long-latency and memory
// writeback sources, with a registered write stage and a starvation stall.
module bp_be_rf_wb_arbiter
  import bp_be_wb_pkg::*;
#(
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned starve_limit_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        pipe_v_i,
  input  logic [reg_addr_width_p-1:0] pipe_addr_i,
  input  logic [dword_width_p-1:0]    pipe_data_i,
  input  logic                        long_v_i,
  input  logic [reg_addr_width_p-1:0] long_addr_i,
  input  logic [dword_width_p-1:0]    long_data_i,
  output logic                        long_ready_o,
  input  logic                        mem_v_i,
  input  logic [reg_addr_width_p-1:0] mem_addr_i,
  input  logic [dword_width_p-1:0]    mem_data_i,
  output logic                        mem_ready_o,
  output logic                        stall_o,
  output logic                        rd_w_v_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic [dword_width_p-1:0]    rd_data_o
);

  localparam int unsigned cnt_width_lp = wb_starve_cnt_width_gp;

  typedef struct packed {
    logic                        v;
    logic [reg_addr_width_p-1:0] addr;
    logic [dword_width_p-1:0]    data;
  } wb_req_s;

  wb_req_s                 pipe_req, long_req, mem_req, wb_n, wb_r;
  bp_be_wb_src_e           src_sel;
  logic                    pipe_take;
  logic                    sec_pending;
  logic [1:0]              grant;
  logic [cnt_width_lp-1:0] starve_cnt_r, starve_cnt_n;

  assign pipe_req    = '{v: pipe_v_i, addr: pipe_addr_i, data: pipe_data_i};
  assign long_req    = '{v: long_v_i, addr: long_addr_i, data: long_data_i};
  assign mem_req     = '{v: mem_v_i,  addr: mem_addr_i,  data: mem_data_i};

  // An x0 pipe write is dropped and leaves the port to the secondaries
  assign pipe_take   = pipe_req.v && (pipe_req.addr != '0);
  assign sec_pending = long_v_i | mem_v_i;

  bp_be_wb_rr_arb2 u_sec_arb (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .v     ({mem_v_i, long_v_i}),
    .en    (!pipe_take),
    .grant (grant)
  );

  assign long_ready_o = grant[0];
  assign mem_ready_o  = grant[1];

  always_comb begin
    src_sel = e_wb_src_none;
    if (pipe_take)     src_sel = e_wb_src_pipe;
    else if (grant[0]) src_sel = e_wb_src_long;
    else if (grant[1]) src_sel = e_wb_src_mem;
  end

  // Address/data hold their last value whenever no write is issued
  always_comb begin
    wb_n   = wb_r;
    wb_n.v = 1'b0;
    case (src_sel)
      e_wb_src_pipe: wb_n = pipe_req;
      e_wb_src_long: if (long_req.addr != '0) wb_n = long_req;
      e_wb_src_mem:  if (mem_req.addr  != '0) wb_n = mem_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) wb_r <= '0;
    else            wb_r <= wb_n;
  end

  assign rd_w_v_o  = wb_r.v;
  assign rd_addr_o = wb_r.addr;
  assign rd_data_o = wb_r.data;

  assign stall_o = (starve_cnt_r == cnt_width_lp'(starve_limit_p));

  // Counts pipe-won cycles while a secondary waits; holds if pipe ignores the stall
  always_comb begin
    starve_cnt_n = '0;
    if (pipe_take && sec_pending) begin
      if (stall_o || (starve_cnt_r == '1)) starve_cnt_n = starve_cnt_r;
      else                                 starve_cnt_n = starve_cnt_r + cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) starve_cnt_r <= '0;
    else            starve_cnt_r <= starve_cnt_n;
  end

  a_no_pipe_on_stall: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(stall_o && pipe_v_i));

endmodule
